an_arbiter: RTL and testbench

Clause 37 auto-negotiation arbiter for the 1000BASE-X PCS. It sequences the transmit datapath by driving `xmit` and `tx_Config_Reg` into the TX top block. It consumes decoded /C/ and /I/ indications from the receive side. It reports the link partner's base page and negotiation completion to management.

---
 rtl/an_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_an_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/an_arbiter.sv
// ---------------------------------------------------------------------------
// an_arbiter -- 1000BASE-X PCS auto-negotiation arbiter.
//
// Sequences the transmit path (xmit / tx_Config_Reg) through the
// auto-negotiation handshake. It consumes decoded /C/ and /I/ strobes from
// the receive side and reports the partner base page and completion status.
//
// Parameters
//   LINK_TIMER_CYCLES : link timer period in clk cycles (>= 2)
//   TIMER_W           : link timer width, must hold LINK_TIMER_CYCLES-1
//
// Ports
//   clk               in   PCS clock, rising edge
//   reset             in   synchronous, active-low reset
//   mr_an_enable      in   management AN enable (level)
//   mr_restart_an     in   management restart request
//   mr_adv_ability    in   local base page (bit 14 replaced by block)
//   sync_status       in   receive synchronization acquired
//   rx_cfg_valid      in   strobe per received /C/ ordered set
//   rx_cfg_reg        in   config word accompanying rx_cfg_valid
//   rx_idle           in   strobe per received /I/ ordered set
//   xmit              out  00 CONFIGURATION, 01 IDLE, 10 DATA
//   tx_Config_Reg     out  config word for /C/ transmission
//   an_complete       out  high only in LINK_OK
//   mr_lp_adv_ability out  latched partner base page
//   an_state          out  current state encoding (debug)
// ---------------------------------------------------------------------------
module an_arbiter #(
    parameter int LINK_TIMER_CYCLES = 1250000,
    parameter int TIMER_W           = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mr_an_enable,
    input  logic        mr_restart_an,
    input  logic [15:0] mr_adv_ability,
    input  logic        sync_status,
    input  logic        rx_cfg_valid,
    input  logic [15:0] rx_cfg_reg,
    input  logic        rx_idle,
    output logic [1:0]  xmit,
    output logic [15:0] tx_Config_Reg,
    output logic        an_complete,
    output logic [15:0] mr_lp_adv_ability,
    output logic [2:0]  an_state
);

    typedef enum logic [2:0] {
        AN_ENABLE            = 3'd0,
        AN_RESTART           = 3'd1,
        ABILITY_DETECT       = 3'd2,
        ACKNOWLEDGE_DETECT   = 3'd3,
        COMPLETE_ACKNOWLEDGE = 3'd4,
        IDLE_DETECT          = 3'd5,
        LINK_OK              = 3'd6,
        AN_DISABLE_LINK_OK   = 3'd7
    } state_e;

    localparam logic [1:0]  XMIT_CONFIG = 2'b00;
    localparam logic [1:0]  XMIT_IDLE   = 2'b01;
    localparam logic [1:0]  XMIT_DATA   = 2'b10;
    // Word comparisons ignore the ACK bit (bit 14).
    localparam logic [15:0] ACK_MASK    = 16'hBFFF;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LINK_TIMER_CYCLES - 1);

    state_e              state_q, state_d;
    logic [1:0]          cfg_cnt_q, cfg_cnt_d;
    logic [1:0]          ack_cnt_q, ack_cnt_d;
    logic [1:0]          idle_cnt_q, idle_cnt_d;
    logic [15:0]         word_q, word_d;
    logic [15:0]         cap_q, cap_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [1:0]          xmit_q, xmit_d;
    logic [15:0]         tx_cfg_q, tx_cfg_d;
    logic                an_complete_q, an_complete_d;
    logic [15:0]         lp_q, lp_d;

    logic ability_match, acknowledge_match, consistency_match;
    logic idle_match, zero_match, timer_done, same_word;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    // Match predicates are pure functions of the counters, so they only
    // change after a strobe has been registered.
    assign ability_match     = (cfg_cnt_q == 2'd3);
    assign acknowledge_match = ability_match && (ack_cnt_q == 2'd3);
    assign consistency_match = ((word_q & ACK_MASK) == (cap_q & ACK_MASK));
    assign idle_match        = (idle_cnt_q == 2'd3);
    assign zero_match        = ability_match && (word_q == 16'h0000);
    assign timer_done        = (timer_q == TIMER_LAST);
    assign same_word         = ((rx_cfg_reg & ACK_MASK) == (word_q & ACK_MASK));

    // Receive match counters. A /C/ strobe wins over a simultaneous /I/.
    // ack_cnt counts consecutive ACK-set words within the current run of
    // identical words, so acknowledge_match needs the last three to carry ACK.
    always_comb begin
        cfg_cnt_d  = cfg_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        idle_cnt_d = idle_cnt_q;
        word_d     = word_q;
        if (state_q == AN_ENABLE || state_q == AN_RESTART) begin
            cfg_cnt_d  = 2'd0;
            ack_cnt_d  = 2'd0;
            idle_cnt_d = 2'd0;
        end else if (rx_cfg_valid) begin
            idle_cnt_d = 2'd0;
            word_d     = rx_cfg_reg;
            if (cfg_cnt_q != 2'd0 && same_word) begin
                cfg_cnt_d = sat_inc(cfg_cnt_q);
                ack_cnt_d = rx_cfg_reg[14] ? sat_inc(ack_cnt_q) : 2'd0;
            end else begin
                cfg_cnt_d = 2'd1;
                ack_cnt_d = rx_cfg_reg[14] ? 2'd1 : 2'd0;
            end
        end else if (rx_idle) begin
            cfg_cnt_d  = 2'd0;
            ack_cnt_d  = 2'd0;
            idle_cnt_d = sat_inc(idle_cnt_q);
        end
    end

    // Next-state logic; the sync/restart overrides take priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AN_ENABLE:
                state_d = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
            AN_RESTART:
                if (timer_done) state_d = ABILITY_DETECT;
            ABILITY_DETECT:
                if (ability_match && !zero_match) state_d = ACKNOWLEDGE_DETECT;
            ACKNOWLEDGE_DETECT:
                if (zero_match) state_d = AN_ENABLE;
                else if (acknowledge_match)
                    state_d = consistency_match ? COMPLETE_ACKNOWLEDGE : AN_ENABLE;
            COMPLETE_ACKNOWLEDGE:
                if (zero_match) state_d = AN_ENABLE;
                else if (timer_done) state_d = IDLE_DETECT;
            IDLE_DETECT:
                if (zero_match) state_d = AN_ENABLE;
                else if (timer_done && idle_match) state_d = LINK_OK;
            LINK_OK:
                if (ability_match) state_d = AN_ENABLE;
            AN_DISABLE_LINK_OK:
                if (mr_an_enable) state_d = AN_ENABLE;
            default:
                state_d = AN_ENABLE;
        endcase
        if (state_q == AN_DISABLE_LINK_OK) begin
            if (mr_restart_an) state_d = AN_ENABLE;
        end else if (!sync_status || mr_restart_an) begin
            state_d = AN_ENABLE;
        end
    end

    // Link timer restarts on entry to the timed states, otherwise saturates.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q &&
            (state_d == AN_RESTART || state_d == COMPLETE_ACKNOWLEDGE ||
             state_d == IDLE_DETECT)) begin
            timer_d = '0;
        end else if (!timer_done) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state register.
    always_comb begin
        xmit_d        = XMIT_CONFIG;
        tx_cfg_d      = tx_cfg_q;
        an_complete_d = 1'b0;
        lp_d          = lp_q;
        cap_d         = cap_q;
        case (state_d)
            AN_ENABLE, AN_RESTART:
                tx_cfg_d = 16'h0000;
            ABILITY_DETECT:
                tx_cfg_d = mr_adv_ability & ACK_MASK;
            ACKNOWLEDGE_DETECT, COMPLETE_ACKNOWLEDGE:
                tx_cfg_d = mr_adv_ability | 16'h4000;
            IDLE_DETECT:
                xmit_d = XMIT_IDLE;
            LINK_OK: begin
                xmit_d        = XMIT_DATA;
                an_complete_d = 1'b1;
            end
            AN_DISABLE_LINK_OK:
                xmit_d = XMIT_DATA;
            default: ;
        endcase
        // Remember the ability word that got us into ACKNOWLEDGE_DETECT.
        if (state_q == ABILITY_DETECT && state_d == ACKNOWLEDGE_DETECT)
            cap_d = word_q;
        if (state_q != COMPLETE_ACKNOWLEDGE && state_d == COMPLETE_ACKNOWLEDGE)
            lp_d = word_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= AN_ENABLE;
            cfg_cnt_q     <= 2'd0;
            ack_cnt_q     <= 2'd0;
            idle_cnt_q    <= 2'd0;
            word_q        <= 16'h0000;
            cap_q         <= 16'h0000;
            timer_q       <= '0;
            xmit_q        <= XMIT_CONFIG;
            tx_cfg_q      <= 16'h0000;
            an_complete_q <= 1'b0;
            lp_q          <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cfg_cnt_q     <= cfg_cnt_d;
            ack_cnt_q     <= ack_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            word_q        <= word_d;
            cap_q         <= cap_d;
            timer_q       <= timer_d;
            xmit_q        <= xmit_d;
            tx_cfg_q      <= tx_cfg_d;
            an_complete_q <= an_complete_d;
            lp_q          <= lp_d;
        end
    end

    assign xmit              = xmit_q;
    assign tx_Config_Reg     = tx_cfg_q;
    assign an_complete       = an_complete_q;
    assign mr_lp_adv_ability = lp_q;
    assign an_state          = state_q;

endmodule

// File: tb/tb_an_arbiter.sv
// ---------------------------------------------------------------------------
// tb_an_arbiter -- table-driven bench for an_arbiter with a short link timer.
// ---------------------------------------------------------------------------
module tb_an_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr_an_enable;
    logic        mr_restart_an;
    logic [15:0] mr_adv_ability;
    logic        sync_status;
    logic        rx_cfg_valid;
    logic [15:0] rx_cfg_reg;
    logic        rx_idle;
    logic [1:0]  xmit;
    logic [15:0] tx_Config_Reg;
    logic        an_complete;
    logic [15:0] mr_lp_adv_ability;
    logic [2:0]  an_state;

    an_arbiter #(.LINK_TIMER_CYCLES(8), .TIMER_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .mr_an_enable      (mr_an_enable),
        .mr_restart_an     (mr_restart_an),
        .mr_adv_ability    (mr_adv_ability),
        .sync_status       (sync_status),
        .rx_cfg_valid      (rx_cfg_valid),
        .rx_cfg_reg        (rx_cfg_reg),
        .rx_idle           (rx_idle),
        .xmit              (xmit),
        .tx_Config_Reg     (tx_Config_Reg),
        .an_complete       (an_complete),
        .mr_lp_adv_ability (mr_lp_adv_ability),
        .an_state          (an_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [15:0] cw;
        logic        idl;
        logic [2:0]  st;
        logic [1:0]  xm;
        logic [15:0] tx;
        logic        anc;
        logic [15:0] lp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [15:0] ADV = 16'h4DE1;
    localparam logic [15:0] TXA = 16'h0DE1;   // ADV with ACK cleared
    localparam logic [15:0] TXK = 16'h4DE1;   // ADV with ACK set

    task automatic push(input logic cv, input logic [15:0] cw, input logic idl,
                        input logic [2:0] st, input logic [1:0] xm,
                        input logic [15:0] tx, input logic anc,
                        input logic [15:0] lp);
        vec_t v;
        v.cv = cv; v.cw = cw; v.idl = idl; v.st = st;
        v.xm = xm; v.tx = tx; v.anc = anc; v.lp = lp;
        vecs.push_back(v);
    endtask

    // Drive one cycle of strobes, then sample just after the rising edge.
    task automatic step(input logic cv, input logic [15:0] cw, input logic idl);
        @(negedge clk);
        rx_cfg_valid = cv;
        rx_cfg_reg   = cw;
        rx_idle      = idl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int n = 0;
        while (an_state !== target && n < budget) begin
            step(1'b0, 16'h0000, 1'b0);
            n++;
        end
        checks++;
        if (an_state !== target) begin
            errors++;
            $display("FAIL wait_state: got %0d expected %0d", an_state, target);
        end
    endtask

    initial begin
        logic [15:0] lp_e;

        reset          = 1'b0;
        mr_an_enable   = 1'b1;
        mr_restart_an  = 1'b0;
        mr_adv_ability = ADV;
        sync_status    = 1'b1;
        rx_cfg_valid   = 1'b0;
        rx_cfg_reg     = 16'h0000;
        rx_idle        = 1'b0;

        // ---- reset state ----
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("rst state", 16'(an_state), 16'd0);
        chk("rst xmit", 16'(xmit), 16'd0);
        chk("rst tx", tx_Config_Reg, 16'h0000);
        chk("rst anc", 16'(an_complete), 16'd0);
        chk("rst lp", mr_lp_adv_ability, 16'h0000);
        $display("reset: state=%0d xmit=%0d tx=%h", an_state, xmit, tx_Config_Reg);
        reset = 1'b1;

        // ---- vector table: one row per clock edge ----
        lp_e = 16'h0000;
        for (int i = 0; i < 8; i++) push(0, 16'h0, 0, 3'd1, 2'd0, 16'h0, 0, lp_e);
        push(0, 16'h0, 0, 3'd2, 2'd0, TXA, 0, lp_e);
        // Ability match; transition one edge after the third strobe.
        for (int i = 0; i < 3; i++) push(1, 16'h01A0, 0, 3'd2, 2'd0, TXA, 0, lp_e);
        push(0, 16'h0, 0, 3'd3, 2'd0, TXK, 0, lp_e);
        for (int i = 0; i < 3; i++) push(1, 16'h41A0, 0, 3'd3, 2'd0, TXK, 0, lp_e);
        lp_e = 16'h41A0;
        for (int i = 0; i < 8; i++) push(0, 16'h0, 0, 3'd4, 2'd0, TXK, 0, lp_e);
        push(0, 16'h0, 0, 3'd5, 2'd1, TXK, 0, lp_e);
        for (int i = 0; i < 3; i++) push(0, 16'h0, 1, 3'd5, 2'd1, TXK, 0, lp_e);
        for (int i = 0; i < 4; i++) push(0, 16'h0, 0, 3'd5, 2'd1, TXK, 0, lp_e);
        push(0, 16'h0, 0, 3'd6, 2'd2, TXK, 1, lp_e);
        // Partner restart seen in LINK_OK.
        for (int i = 0; i < 3; i++) push(1, 16'h0000, 0, 3'd6, 2'd2, TXK, 1, lp_e);
        push(0, 16'h0, 0, 3'd0, 2'd0, 16'h0, 0, lp_e);
        for (int i = 0; i < 8; i++) push(0, 16'h0, 0, 3'd1, 2'd0, 16'h0, 0, lp_e);
        push(0, 16'h0, 0, 3'd2, 2'd0, TXA, 0, lp_e);
        // Null page must not advance ABILITY_DETECT.
        for (int i = 0; i < 3; i++) push(1, 16'h0000, 0, 3'd2, 2'd0, TXA, 0, lp_e);
        push(0, 16'h0, 0, 3'd2, 2'd0, TXA, 0, lp_e);
        // Inconsistent acknowledge returns to AN_ENABLE.
        for (int i = 0; i < 3; i++) push(1, 16'h01A0, 0, 3'd2, 2'd0, TXA, 0, lp_e);
        push(0, 16'h0, 0, 3'd3, 2'd0, TXK, 0, lp_e);
        for (int i = 0; i < 3; i++) push(1, 16'h4020, 0, 3'd3, 2'd0, TXK, 0, lp_e);
        push(0, 16'h0, 0, 3'd0, 2'd0, 16'h0, 0, lp_e);
        push(0, 16'h0, 0, 3'd1, 2'd0, 16'h0, 0, lp_e);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cv, vecs[i].cw, vecs[i].idl);
            $display("vec %0d: cv=%0d cw=%h idle=%0d -> state=%0d xmit=%0d tx=%h anc=%0d lp=%h",
                     i, vecs[i].cv, vecs[i].cw, vecs[i].idl, an_state, xmit,
                     tx_Config_Reg, an_complete, mr_lp_adv_ability);
            chk($sformatf("v%0d state", i), 16'(an_state), 16'(vecs[i].st));
            chk($sformatf("v%0d xmit", i), 16'(xmit), 16'(vecs[i].xm));
            chk($sformatf("v%0d tx", i), tx_Config_Reg, vecs[i].tx);
            chk($sformatf("v%0d anc", i), 16'(an_complete), 16'(vecs[i].anc));
            chk($sformatf("v%0d lp", i), mr_lp_adv_ability, vecs[i].lp);
        end

        // ---- simultaneous strobes (config wins), then sync loss in IDLE_DETECT ----
        wait_state(3'd2, 20);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0120, 1'b1);
        chk("both strobes hold", 16'(an_state), 16'd2);
        step(1'b0, 16'h0000, 1'b0);
        chk("both strobes ack", 16'(an_state), 16'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h4120, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("cplt state", 16'(an_state), 16'd4);
        chk("cplt lp", mr_lp_adv_ability, 16'h4120);
        wait_state(3'd5, 20);
        $display("seq sync: state=%0d xmit=%0d", an_state, xmit);
        sync_status = 1'b0;
        step(1'b0, 16'h0000, 1'b0);
        chk("sync drop state", 16'(an_state), 16'd0);
        chk("sync drop xmit", 16'(xmit), 16'd0);
        sync_status = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        chk("sync back state", 16'(an_state), 16'd1);

        // ---- mid-negotiation reset with AN disabled ----
        reset        = 1'b0;
        mr_an_enable = 1'b0;
        step(1'b0, 16'h0000, 1'b0);
        chk("rst2 state", 16'(an_state), 16'd0);
        chk("rst2 lp", mr_lp_adv_ability, 16'h0000);
        reset = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        $display("seq disable: state=%0d xmit=%0d anc=%0d", an_state, xmit, an_complete);
        chk("dis state", 16'(an_state), 16'd7);
        chk("dis xmit", 16'(xmit), 16'd2);
        chk("dis anc", 16'(an_complete), 16'd0);
        step(1'b0, 16'h0000, 1'b0);
        chk("dis hold", 16'(an_state), 16'd7);
        mr_restart_an = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        chk("restart in dis", 16'(an_state), 16'd0);
        mr_restart_an = 1'b0;
        step(1'b0, 16'h0000, 1'b0);
        chk("back to dis", 16'(an_state), 16'd7);
        mr_an_enable = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        chk("enable state", 16'(an_state), 16'd0);
        step(1'b0, 16'h0000, 1'b0);
        chk("enable restart", 16'(an_state), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
